// File: rtl/lc3_mem_pkg.sv
// -----------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC-3 memory-side responder: the access FSM state
// type and the memory-mapped I/O address map (keyboard and display registers).
// -----------------------------------------------------------------------------
package lc3_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Everything at or above this address is MMIO, never RAM.
   localparam logic [15:0] MMIO_BASE = 16'hFE00;

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// lc3_mem_ctrl_if
// MAR/MDR access bus between the LC-3 control unit (master) and the memory
// responder (slave).
//   mio_en   : access request, held by the master until it sees ready
//   r_w      : 1 = write, 0 = read
//   mar      : access address
//   mdr_in   : write data
//   mem_data : read result, holds until the next read completes
//   ready    : one-cycle completion pulse (LC-3 R)
// -----------------------------------------------------------------------------
interface lc3_mem_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);

   logic                  mio_en;
   logic                  r_w;
   logic [ADDR_WIDTH-1:0] mar;
   logic [DATA_WIDTH-1:0] mdr_in;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  ready;

   modport master (
      output mio_en, r_w, mar, mdr_in,
      input  mem_data, ready
   );

   modport slave (
      input  mio_en, r_w, mar, mdr_in,
      output mem_data, ready
   );

endinterface

// File: rtl/lc3_mmio_regs.sv
// -----------------------------------------------------------------------------
// lc3_mmio_regs
// Keyboard receive buffer, display holding register and the MMIO read mux.
//   clk, rst_n  : clock, asynchronous active-low reset
//   addr        : registered access address from the controller
//   is_write    : latched access direction
//   commit      : high in the controller's DONE cycle; side effects land on
//                 the edge that ends it
//   wdata       : low byte of the latched write data
//   rdata       : MMIO read value for addr (0 for unmapped addresses)
//   kb_valid/kb_data       : keyboard character strobe and character
//   disp_valid/disp_data   : pending display character
//   disp_ready             : display consumes the character when high with
//                            disp_valid
// -----------------------------------------------------------------------------
module lc3_mmio_regs
   import lc3_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  is_write,
   input  logic                  commit,
   input  logic [7:0]            wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   input  logic                  kb_valid,
   input  logic [7:0]            kb_data,
   output logic                  disp_valid,
   output logic [7:0]            disp_data,
   input  logic                  disp_ready
);

   logic       kb_full;
   logic [7:0] kb_buf;

   logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
   logic kb_clr, ddr_wr;

   assign sel_kbsr = (addr == ADDR_WIDTH'(KBSR_ADDR));
   assign sel_kbdr = (addr == ADDR_WIDTH'(KBDR_ADDR));
   assign sel_dsr  = (addr == ADDR_WIDTH'(DSR_ADDR));
   assign sel_ddr  = (addr == ADDR_WIDTH'(DDR_ADDR));

   assign kb_clr = commit && !is_write && sel_kbdr;
   assign ddr_wr = commit &&  is_write && sel_ddr;

   always_comb begin
      rdata = '0;
      if (sel_kbsr) begin
         rdata[DATA_WIDTH-1] = kb_full;
      end else if (sel_kbdr) begin
         rdata[7:0] = kb_buf;
      end else if (sel_dsr) begin
         rdata[DATA_WIDTH-1] = ~disp_valid;
      end
   end

   // A character arriving on the same edge as a KBDR-read clear wins: the
   // buffer reloads and stays full. While full, new characters are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kb_full <= 1'b0;
         kb_buf  <= '0;
      end else if (kb_valid && (!kb_full || kb_clr)) begin
         kb_full <= 1'b1;
         kb_buf  <= kb_data;
      end else if (kb_clr) begin
         kb_full <= 1'b0;
      end
   end

   // DDR writes are dropped while a character is still pending, so
   // disp_data never changes under the display's feet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_valid <= 1'b0;
         disp_data  <= '0;
      end else if (disp_valid) begin
         if (disp_ready) begin
            disp_valid <= 1'b0;
         end
      end else if (ddr_wr) begin
         disp_valid <= 1'b1;
         disp_data  <= wdata;
      end
   end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lc3_mem_ctrl
// Memory-side responder for the LC-3 MAR/MDR bus. Takes one access at a time,
// completes it against a synchronous-read RAM or the MMIO registers, and
// pulses ready LATENCY cycles after the request is sampled.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : mio_en, r_w, mar, mdr_in in; mem_data, ready out
//   ram_addr/ram_wdata: registered RAM address and write data
//   ram_we            : one-cycle RAM write strobe (RAM addresses only)
//   ram_rdata         : RAM read data, valid one cycle after ram_addr
//   kb_valid/kb_data  : keyboard input
//   disp_valid/disp_data/disp_ready : display output handshake
// -----------------------------------------------------------------------------
module lc3_mem_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int LATENCY    = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   lc3_mem_ctrl_if.slave         bus,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   input  logic                  kb_valid,
   input  logic [7:0]            kb_data,
   output logic                  disp_valid,
   output logic [7:0]            disp_data,
   input  logic                  disp_ready
);

   localparam int               CNT_W    = $clog2(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic                  is_write;
   logic                  is_ram;
   logic [DATA_WIDTH-1:0] mmio_rdata;

   assign is_ram = (ram_addr < ADDR_WIDTH'(MMIO_BASE));

   lc3_mmio_regs #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mmio (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (ram_addr),
      .is_write   (is_write),
      .commit     (state == ST_DONE),
      .wdata      (ram_wdata[7:0]),
      .rdata      (mmio_rdata),
      .kb_valid   (kb_valid),
      .kb_data    (kb_data),
      .disp_valid (disp_valid),
      .disp_data  (disp_data),
      .disp_ready (disp_ready)
   );

   // ram_addr is stable from the IDLE->WAIT edge, so ram_rdata is valid well
   // before the WAIT->DONE capture edge. ram_we is raised on the edge where
   // the counter reaches 0, making it high during the last WAIT cycle so the
   // RAM commits on the WAIT->DONE edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         is_write     <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         ram_we       <= 1'b0;
         bus.ready    <= 1'b0;
         bus.mem_data <= '0;
      end else begin
         ram_we    <= 1'b0;
         bus.ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.mio_en) begin
                  ram_addr  <= bus.mar;
                  ram_wdata <= bus.mdr_in;
                  is_write  <= bus.r_w;
                  cnt       <= CNT_LOAD;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state     <= ST_DONE;
                  bus.ready <= 1'b1;
                  if (!is_write) begin
                     bus.mem_data <= is_ram ? ram_rdata : mmio_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1) && is_write && is_ram) begin
                     ram_we <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lc3_mem_ctrl
// Self-checking bench for lc3_mem_ctrl with a behavioural synchronous RAM.
// Unwritten RAM words read as (address ^ 16'h5A5A).
// -----------------------------------------------------------------------------
module tb_lc3_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        kb_valid;
   logic [7:0]  kb_data;
   logic        disp_valid;
   logic [7:0]  disp_data;
   logic        disp_ready;

   lc3_mem_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   lc3_mem_ctrl #(
      .LATENCY    (4),
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .kb_valid   (kb_valid),
      .kb_data    (kb_data),
      .disp_valid (disp_valid),
      .disp_data  (disp_data),
      .disp_ready (disp_ready)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM model
   logic [15:0] mem     [0:65535];
   bit          written [0:65535];

   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr]     <= ram_wdata;
         written[ram_addr] <= 1'b1;
      end
      ram_rdata <= written[ram_addr] ? mem[ram_addr] : (ram_addr ^ 16'h5A5A);
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One access from the master side. Cycle c is counted at the negedge
   // following request-sample edge c-1.
   task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                         input bit kb_at_done, input logic [7:0] kbd,
                         output logic [15:0] data, output int rcyc,
                         output int wcnt, output int wcyc);
      rcyc = 0; wcnt = 0; wcyc = 0; data = 'x;
      @(negedge clk);
      bus.mio_en = 1'b1; bus.r_w = w; bus.mar = a; bus.mdr_in = d;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (ram_we) begin
            wcnt++;
            wcyc = c;
         end
         if (bus.ready) begin
            rcyc = c;
            data = bus.mem_data;
            bus.mio_en = 1'b0;
            if (kb_at_done) begin
               kb_valid = 1'b1;
               kb_data  = kbd;
            end
            break;
         end
      end
      bus.mio_en = 1'b0;
      @(negedge clk);
      kb_valid = 1'b0;
      chk($sformatf("ready_pulse_%h", a), {31'b0, bus.ready}, 32'd0);
   endtask

   task automatic kb_pulse(input logic [7:0] ch);
      @(negedge clk);
      kb_valid = 1'b1; kb_data = ch;
      @(negedge clk);
      kb_valid = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp,
                         input bit kb_at_done, input logic [7:0] kbd);
      logic [15:0] d;
      int rc, wc, wy;
      access(1'b0, a, 16'h0, kb_at_done, kbd, d, rc, wc, wy);
      chk({name, "_cycle"}, rc, 4);
      chk({name, "_data"}, {16'b0, d}, {16'b0, exp});
   endtask

   typedef struct {
      bit          w;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_data;
      int          exp_we;
   } vec_t;

   vec_t vecs [10];

   logic [15:0] rd, d1, d2;
   int rc, wc, wy, c1, c2, nrdy, nwe;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // write-vector exp_data is the value left from the previous read
      vecs[0] = '{1'b1, 16'h3000, 16'hBEEF, 16'h0000, 1};
      vecs[1] = '{1'b0, 16'h3000, 16'h0000, 16'hBEEF, 0};
      vecs[2] = '{1'b1, 16'hFDFF, 16'h1111, 16'hBEEF, 1};
      vecs[3] = '{1'b0, 16'hFDFF, 16'h0000, 16'h1111, 0};
      vecs[4] = '{1'b1, 16'hFE00, 16'hAAAA, 16'h1111, 0};
      vecs[5] = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 0};
      vecs[6] = '{1'b1, 16'hFFFF, 16'h2222, 16'h0000, 0};
      vecs[7] = '{1'b0, 16'h0005, 16'h0000, 16'h5A5F, 0};
      vecs[8] = '{1'b0, 16'hFE04, 16'h0000, 16'h8000, 0};
      vecs[9] = '{1'b0, 16'hFE08, 16'h0000, 16'h0000, 0};

      rst_n = 1'b0;
      bus.mio_en = 1'b0; bus.r_w = 1'b0; bus.mar = '0; bus.mdr_in = '0;
      kb_valid = 1'b0; kb_data = '0; disp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready",      {31'b0, bus.ready},     32'd0);
      chk("rst_mem_data",   {16'b0, bus.mem_data},  32'd0);
      chk("rst_ram_addr",   {16'b0, ram_addr},      32'd0);
      chk("rst_ram_wdata",  {16'b0, ram_wdata},     32'd0);
      chk("rst_ram_we",     {31'b0, ram_we},        32'd0);
      chk("rst_disp_valid", {31'b0, disp_valid},    32'd0);
      chk("rst_disp_data",  {24'b0, disp_data},     32'd0);
      rst_n = 1'b1;

      // Table-driven single accesses
      for (int i = 0; i < 10; i++) begin
         access(vecs[i].w, vecs[i].addr, vecs[i].wdata, 1'b0, 8'h00, rd, rc, wc, wy);
         chk($sformatf("v%0d_ready_cycle", i), rc, 4);
         chk($sformatf("v%0d_we_count", i), wc, vecs[i].exp_we);
         if (vecs[i].exp_we != 0) chk($sformatf("v%0d_we_cycle", i), wy, 3);
         chk($sformatf("v%0d_mem_data", i), {16'b0, rd}, {16'b0, vecs[i].exp_data});
      end

      // Keyboard: second character dropped while full
      kb_pulse(8'h41);
      kb_pulse(8'h42);
      rd_chk("kbsr_full",  16'hFE00, 16'h8000, 1'b0, 8'h00);
      rd_chk("kbdr_41",    16'hFE02, 16'h0041, 1'b0, 8'h00);
      rd_chk("kbsr_empty", 16'hFE00, 16'h0000, 1'b0, 8'h00);

      // KBDR read clear coinciding with a new character
      kb_pulse(8'h44);
      rd_chk("kbdr_44_race", 16'hFE02, 16'h0044, 1'b1, 8'h43);
      rd_chk("kbsr_race",    16'hFE00, 16'h8000, 1'b0, 8'h00);
      rd_chk("kbdr_43",      16'hFE02, 16'h0043, 1'b0, 8'h00);
      rd_chk("kbsr_after",   16'hFE00, 16'h0000, 1'b0, 8'h00);

      // Display
      access(1'b1, 16'hFE06, 16'h0058, 1'b0, 8'h00, rd, rc, wc, wy);
      chk("ddr_we_count", wc, 0);
      chk("ddr_disp_valid", {31'b0, disp_valid}, 32'd1);
      chk("ddr_disp_data",  {24'b0, disp_data},  32'h58);
      rd_chk("dsr_busy", 16'hFE04, 16'h0000, 1'b0, 8'h00);
      access(1'b1, 16'hFE06, 16'h0059, 1'b0, 8'h00, rd, rc, wc, wy);
      chk("ddr_ignored_data",  {24'b0, disp_data},  32'h58);
      chk("ddr_ignored_valid", {31'b0, disp_valid}, 32'd1);
      @(negedge clk);
      disp_ready = 1'b1;
      @(negedge clk);
      disp_ready = 1'b0;
      chk("disp_consumed", {31'b0, disp_valid}, 32'd0);
      chk("disp_data_hold", {24'b0, disp_data}, 32'h58);
      rd_chk("dsr_idle", 16'hFE04, 16'h8000, 1'b0, 8'h00);

      // Held mio_en: two back-to-back reads
      nrdy = 0; c1 = 0; c2 = 0; d1 = '0; d2 = '0;
      @(negedge clk);
      bus.mio_en = 1'b1; bus.r_w = 1'b0; bus.mar = 16'h0010;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (bus.ready) begin
            nrdy++;
            if (nrdy == 1) begin
               c1 = c; d1 = bus.mem_data; bus.mar = 16'h0011;
            end else begin
               c2 = c; d2 = bus.mem_data; bus.mio_en = 1'b0;
               break;
            end
         end
      end
      bus.mio_en = 1'b0;
      chk("b2b_first_cycle",  c1, 4);
      chk("b2b_first_data",   {16'b0, d1}, 32'h5A4A);
      chk("b2b_second_cycle", c2, 9);
      chk("b2b_second_data",  {16'b0, d2}, 32'h5A4B);
      @(negedge clk);

      // Reset during WAIT of a write to x4000
      nrdy = 0; nwe = 0;
      @(negedge clk);
      bus.mio_en = 1'b1; bus.r_w = 1'b1; bus.mar = 16'h4000; bus.mdr_in = 16'h7777;
      @(negedge clk);
      rst_n = 1'b0;
      bus.mio_en = 1'b0;
      #1;
      chk("abort_ready",      {31'b0, bus.ready},    32'd0);
      chk("abort_ram_we",     {31'b0, ram_we},       32'd0);
      chk("abort_mem_data",   {16'b0, bus.mem_data}, 32'd0);
      chk("abort_ram_addr",   {16'b0, ram_addr},     32'd0);
      chk("abort_ram_wdata",  {16'b0, ram_wdata},    32'd0);
      chk("abort_disp_data",  {24'b0, disp_data},    32'd0);
      chk("abort_disp_valid", {31'b0, disp_valid},   32'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 1) rst_n = 1'b1;
         if (bus.ready) nrdy++;
         if (ram_we) nwe++;
      end
      chk("abort_no_ready", nrdy, 0);
      chk("abort_no_we",    nwe,  0);
      rd_chk("abort_x4000", 16'h4000, 16'h1A5A, 1'b0, 8'h00);
      rd_chk("abort_kbsr",  16'hFE00, 16'h0000, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
